// File: rtl/mult_controller.sv
// -----------------------------------------------------------------------------
// mult_controller
//   Sequencer for the iterative HI/LO multiplier in the execute stage.
//   A multiply is accepted on start_E. The controller then runs a radix-2
//   shift-add loop on the operand magnitudes for WIDTH cycles. A final fix-up
//   cycle applies the sign and writes {hi,lo}. It also handles mthi/mtlo
//   writes while idle, and requests a pipeline stall while a multiply is in
//   flight and the execute stage holds a dependent HI/LO operation.
//
// Ports
//   clk         rising-edge pipeline clock
//   reset       asynchronous, active-low; clears all state
//   start_E     multiply request (mult/multu) from execute
//   multSign_E  1 = signed multiply, 0 = unsigned
//   srcA_E      multiplicand
//   srcB_E      multiplier
//   abort       pipeline flush; cancels an in-flight multiply
//   hiRead      mfhi in execute
//   loRead      mflo in execute
//   hiWrite     mthi in execute
//   loWrite     mtlo in execute
//   wrData      data for mthi/mtlo
//   hi, lo      HI/LO result registers
//   busy        multiply in flight
//   done        one-cycle pulse in the cycle after hi/lo are written
//   stall_mult  combinational stall request to the hazard unit
// -----------------------------------------------------------------------------
module mult_controller #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_E,
    input  logic             multSign_E,
    input  logic [WIDTH-1:0] srcA_E,
    input  logic [WIDTH-1:0] srcB_E,
    input  logic             abort,
    input  logic             hiRead,
    input  logic             loRead,
    input  logic             hiWrite,
    input  logic             loWrite,
    input  logic [WIDTH-1:0] wrData,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall_mult
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplr_q,  mplr_d;
    logic [WIDTH-1:0]   acc_q,   acc_d;
    logic               negate_q, negate_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   hi_q,    hi_d;
    logic [WIDTH-1:0]   lo_q,    lo_d;
    logic               done_q,  done_d;

    logic [WIDTH:0]     sum;       // carry + accumulator after the conditional add
    logic [2*WIDTH:0]   shifted;   // {carry, acc, mplr} shifted right by one
    logic [2*WIDTH-1:0] prod;      // unsigned product of the magnitudes
    logic [2*WIDTH-1:0] result;    // signed-corrected product

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        acc_d    = acc_q;
        negate_d = negate_q;
        count_d  = count_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        sum     = mplr_q[0] ? ({1'b0, acc_q} + {1'b0, mcand_q}) : {1'b0, acc_q};
        shifted = {sum, mplr_q} >> 1;
        prod    = {acc_q, mplr_q};
        result  = negate_q ? -prod : prod;

        case (state_q)
            S_IDLE: begin
                // A flush kills a start presented on the same edge.
                if (start_E && !abort) begin
                    // Magnitudes are held unsigned, so -(2^(WIDTH-1)) maps
                    // cleanly onto 2^(WIDTH-1) without overflow.
                    mcand_d  = (multSign_E && srcA_E[WIDTH-1]) ? -srcA_E : srcA_E;
                    mplr_d   = (multSign_E && srcB_E[WIDTH-1]) ? -srcB_E : srcB_E;
                    negate_d = multSign_E & (srcA_E[WIDTH-1] ^ srcB_E[WIDTH-1]);
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = S_BUSY;
                end else begin
                    // Writes only land when no multiply is being started.
                    if (hiWrite) hi_d = wrData;
                    if (loWrite) lo_d = wrData;
                end
            end
            S_BUSY: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d   = shifted[2*WIDTH-1:WIDTH];
                    mplr_d  = shifted[WIDTH-1:0];
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(WIDTH - 1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!abort) begin
                    hi_d   = result[2*WIDTH-1:WIDTH];
                    lo_d   = result[WIDTH-1:0];
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplr_q   <= '0;
            acc_q    <= '0;
            negate_q <= 1'b0;
            count_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            acc_q    <= acc_d;
            negate_q <= negate_d;
            count_q  <= count_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign hi         = hi_q;
    assign lo         = lo_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign stall_mult = busy & (hiRead | loRead | hiWrite | loWrite | start_E);

endmodule

// File: tb/tb_mult_controller.sv
// -----------------------------------------------------------------------------
// tb_mult_controller
//   Randomised self-checking bench for mult_controller. Expected HI/LO values
//   come from a transaction-level model: a 64-bit product computed with plain
//   signed/unsigned arithmetic, plus the mthi/mtlo register writes. Timing
//   expectations (33 busy cycles, done pulse, stall behaviour) are checked
//   per transaction.
// -----------------------------------------------------------------------------
module tb_mult_controller;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_E, multSign_E, abort;
    logic [W-1:0]  srcA_E, srcB_E, wrData;
    logic          hiRead, loRead, hiWrite, loWrite;
    logic [W-1:0]  hi, lo;
    logic          busy, done, stall_mult;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [W-1:0]  m_hi = '0;
    logic [W-1:0]  m_lo = '0;

    always #5 clk = ~clk;

    mult_controller #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_E    (start_E),
        .multSign_E (multSign_E),
        .srcA_E     (srcA_E),
        .srcB_E     (srcB_E),
        .abort      (abort),
        .hiRead     (hiRead),
        .loRead     (loRead),
        .hiWrite    (hiWrite),
        .loWrite    (loWrite),
        .wrData     (wrData),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .stall_mult (stall_mult)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sgn);
        logic signed [63:0] sa, sb;
        if (sgn) begin
            sa = {{W{a[W-1]}}, a};
            sb = {{W{b[W-1]}}, b};
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // One complete multiply transaction with optional dependent read held
    // during the run, a spurious start 5 cycles in, and an mthi on the start edge.
    task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                            input bit hold_read, input bit spurious, input bit with_write);
        logic [63:0] prod;
        int busy_cyc, done_seen, stall_bad, hi_bad;
        prod = model(a, b, sgn);
        start_E = 1'b1; multSign_E = sgn; srcA_E = a; srcB_E = b;
        hiWrite = with_write; wrData = $urandom;
        tick();
        start_E = 1'b0; hiWrite = 1'b0;
        srcA_E = $urandom; srcB_E = $urandom; multSign_E = $urandom_range(0, 1);
        hiRead = hold_read;
        busy_cyc = 0; done_seen = 0; stall_bad = 0; hi_bad = 0;
        while (busy && busy_cyc < 100) begin
            busy_cyc++;
            start_E = (spurious && busy_cyc == 5);
            #1;
            if (done) done_seen++;
            if (stall_mult !== (hold_read | start_E)) stall_bad++;
            if (hi !== m_hi || lo !== m_lo) hi_bad++;
            if (spurious && busy_cyc == 5) chk("spurious_start_stall", stall_mult, 1);
            tick();
        end
        start_E = 1'b0;
        m_hi = prod[63:32];
        m_lo = prod[31:0];
        chk("busy_cycles", busy_cyc, 33);
        chk("done_during_busy", done_seen, 0);
        chk("stall_during_busy", stall_bad, 0);
        chk("hilo_stable_during_busy", hi_bad, 0);
        chk("hi_result", hi, m_hi);
        chk("lo_result", lo, m_lo);
        chk("done_pulse", done, 1);
        chk("stall_after_fix", stall_mult, 0);
        hiRead = 1'b0;
        tick();
        chk("done_one_cycle", done, 0);
        $display("mult a=%h b=%h signed=%0d read=%0d spur=%0d wr=%0d -> hi=%h lo=%h",
                 a, b, sgn, hold_read, spurious, with_write, hi, lo);
    endtask

    task automatic idle_write(input bit wh, input bit wl, input logic [W-1:0] d);
        hiWrite = wh; loWrite = wl; wrData = d;
        tick();
        hiWrite = 1'b0; loWrite = 1'b0;
        if (wh) m_hi = d;
        if (wl) m_lo = d;
        chk("mthi", hi, m_hi);
        chk("mtlo", lo, m_lo);
        $display("write hi=%0d lo=%0d data=%h -> hi=%h lo=%h", wh, wl, d, hi, lo);
    endtask

    initial begin
        reset = 1'b0; start_E = 1'b0; multSign_E = 1'b0; abort = 1'b0;
        srcA_E = '0; srcB_E = '0; wrData = '0;
        hiRead = 1'b0; loRead = 1'b0; hiWrite = 1'b0; loWrite = 1'b0;
        tick(); tick();
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_stall", stall_mult, 0);
        reset = 1'b1;
        tick();

        // Directed corner products.
        run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        run_mult(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 1'b1, 1'b0, 1'b0);
        run_mult(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b0);

        // Abort after presetting hi/lo.
        idle_write(1'b1, 1'b0, 32'h0000_1234);
        idle_write(1'b0, 1'b1, 32'h0000_5678);
        start_E = 1'b1; multSign_E = 1'b0; srcA_E = 32'd7; srcB_E = 32'd9;
        tick();
        start_E = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_hi", hi, 32'h0000_1234);
        chk("abort_lo", lo, 32'h0000_5678);
        chk("abort_done", done, 0);
        tick();
        chk("abort_done_next", done, 0);
        $display("abort hi=%h lo=%h", hi, lo);

        // Start with mthi on the same edge: write is dropped.
        run_mult(32'h0000_0003, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);

        // Randomised mix of multiplies and idle writes.
        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 3) == 0)
                idle_write($urandom_range(0, 1), $urandom_range(0, 1), $urandom);
            else
                run_mult(pick(), pick(), $urandom_range(0, 1), $urandom_range(0, 1),
                         ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset in the middle of a run.
        start_E = 1'b1; multSign_E = 1'b1; srcA_E = 32'h1234_5678; srcB_E = 32'h9ABC_DEF0;
        tick();
        start_E = 1'b0; hiRead = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("pre_reset_stall", stall_mult, 1);
        reset = 1'b0;
        #1;
        chk("async_reset_hi", hi, 0);
        chk("async_reset_lo", lo, 0);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_stall", stall_mult, 0);
        chk("async_reset_done", done, 0);
        m_hi = '0; m_lo = '0;
        hiRead = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        $display("reset during busy hi=%h lo=%h", hi, lo);

        run_mult(32'h0000_0006, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
